// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer and its 1-bit slice.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  localparam logic [2:0] BONUS_LT = 3'b000;
  localparam logic [2:0] BONUS_GT = 3'b001;
  localparam logic [2:0] BONUS_LE = 3'b010;
  localparam logic [2:0] BONUS_GE = 3'b011;
  localparam logic [2:0] BONUS_EQ = 3'b110;
  localparam logic [2:0] BONUS_NE = 3'b100;

  // Derive the selected relation from the signed less/equal flags.
  function automatic logic compare_pick(input logic [2:0] bonus, input logic less, input logic equal);
    logic pick;
    case (bonus)
      BONUS_LT: pick = less;
      BONUS_GT: pick = ~less & ~equal;
      BONUS_LE: pick = less | equal;
      BONUS_GE: pick = ~less;
      BONUS_EQ: pick = equal;
      BONUS_NE: pick = ~equal;
      default:  pick = 1'b0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/serial_alu_seq_slice.sv
// 1-bit ALU slice (alu_top): AND/OR/ADD plus a compare output that consumes
// externally computed less/equal flags.
module alu_top
  import serial_alu_pkg::*;
(
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       equal,
  input  logic       A_invert,
  input  logic       B_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  input  logic       comp,
  input  logic [2:0] bonus,
  output logic       result,
  output logic       cout
);

  logic a_s;
  logic b_s;
  logic sum_s;

  assign a_s   = src1 ^ A_invert;
  assign b_s   = src2 ^ B_invert;
  assign sum_s = a_s ^ b_s ^ cin;
  assign cout  = (a_s & b_s) | (a_s & cin) | (b_s & cin);

  // Result mux; op 11 returns the compare bit when comp is set, else raw less.
  always_comb begin
    result = 1'b0;
    case (operation)
      OP_AND: result = a_s & b_s;
      OP_OR:  result = a_s | b_s;
      OP_ADD: result = sum_s;
      OP_SLT: begin
        if (comp) begin
          result = compare_pick(bonus, less, equal);
        end else begin
          result = less;
        end
      end
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// WIDTH-bit multi-cycle ALU built from one 1-bit slice, one bit per clock, LSB first.
// Define SERIAL_ALU_BONUS_EN to enable the full bonus_i compare decoding.
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ALU_control_i,
  input  logic [2:0]       bonus_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIDTH-1:0] src1_r;
  logic [WIDTH-1:0] src2_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_nxt_s;
  logic [WIDTH-1:0] result_r;
  logic [3:0]       ctrl_r;
  logic [2:0]       bonus_r;
  logic [2:0]       bonus_sel_s;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             eq_acc_r;
  logic             set_r;
  logic             cin_msb_r;
  logic             cout_msb_r;
  logic             zero_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;
  logic             last_bit_s;
  logic             is_cmp_op_s;
  logic             slice_a_s;
  logic             slice_b_s;
  logic             slice_less_s;
  logic             slice_comp_s;
  logic [1:0]       slice_op_s;
  logic             slice_res_s;
  logic             slice_cout_s;

`ifdef SERIAL_ALU_BONUS_EN
  assign bonus_sel_s = bonus_i;
`else
  logic bonus_unused_s;
  assign bonus_unused_s = ^bonus_i;
  assign bonus_sel_s    = BONUS_LT;
`endif

  assign last_bit_s  = (cnt_r == CNT_LAST);
  assign is_cmp_op_s = (ctrl_r[1:0] == OP_SLT);
  assign shift_nxt_s = {slice_res_s, shift_r[WIDTH-1:1]};

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_nxt_s = is_cmp_op_s ? ST_CMP : ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_CMP:  state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Slice input steering: compare ops run as a subtract, then one compare evaluation.
  always_comb begin
    slice_a_s    = src1_r[cnt_r];
    slice_b_s    = src2_r[cnt_r];
    slice_less_s = set_r ^ cin_msb_r ^ cout_msb_r;
    slice_op_s   = ctrl_r[1:0];
    slice_comp_s = 1'b0;
    if (state_r == ST_CMP) begin
      slice_op_s   = OP_SLT;
      slice_comp_s = 1'b1;
    end else if (is_cmp_op_s) begin
      slice_op_s   = OP_ADD;
      slice_comp_s = 1'b0;
    end else begin
      slice_op_s   = ctrl_r[1:0];
      slice_comp_s = 1'b0;
    end
  end

  alu_top u_slice (
    .src1      (slice_a_s),
    .src2      (slice_b_s),
    .less      (slice_less_s),
    .equal     (eq_acc_r),
    .A_invert  (ctrl_r[3]),
    .B_invert  (ctrl_r[2]),
    .cin       (carry_r),
    .operation (slice_op_s),
    .comp      (slice_comp_s),
    .bonus     (bonus_r),
    .result    (slice_res_s),
    .cout      (slice_cout_s)
  );

  // State register and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_CMP);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand capture, serial datapath, and result/flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src1_r     <= {WIDTH{1'b0}};
      src2_r     <= {WIDTH{1'b0}};
      shift_r    <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      ctrl_r     <= 4'b0000;
      bonus_r    <= 3'b000;
      cnt_r      <= {CW{1'b0}};
      carry_r    <= 1'b0;
      eq_acc_r   <= 1'b0;
      set_r      <= 1'b0;
      cin_msb_r  <= 1'b0;
      cout_msb_r <= 1'b0;
      zero_r     <= 1'b0;
      cout_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            src1_r   <= src1_i;
            src2_r   <= src2_i;
            ctrl_r   <= ALU_control_i;
            bonus_r  <= bonus_sel_s;
            carry_r  <= ALU_control_i[2];
            cnt_r    <= {CW{1'b0}};
            eq_acc_r <= 1'b1;
          end
        end
        ST_RUN: begin
          shift_r <= shift_nxt_s;
          carry_r <= slice_cout_s;
          if (slice_res_s) begin
            eq_acc_r <= 1'b0;
          end
          if (last_bit_s) begin
            set_r      <= slice_res_s;
            cin_msb_r  <= carry_r;
            cout_msb_r <= slice_cout_s;
            if (!is_cmp_op_s) begin
              result_r <= shift_nxt_s;
              zero_r   <= (shift_nxt_s == {WIDTH{1'b0}});
              cout_r   <= slice_cout_s;
              ovf_r    <= (ctrl_r[1:0] == OP_ADD) ? (carry_r ^ slice_cout_s) : 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        ST_CMP: begin
          result_r <= {{(WIDTH-1){1'b0}}, slice_res_s};
          zero_r   <= ~slice_res_s;
          cout_r   <= cout_msb_r;
          ovf_r    <= 1'b0;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign result_o   = result_r;
  assign zero_o     = zero_r;
  assign cout_o     = cout_r;
  assign overflow_o = ovf_r;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq (WIDTH=32): arithmetic reference model,
// per-cycle output compare, and directed vectors with hand-computed results.
module tb_serial_alu_seq;

  localparam int W = 32;
`ifdef SERIAL_ALU_BONUS_EN
  localparam bit BONUS_ON = 1'b1;
`else
  localparam bit BONUS_ON = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] src1  = '0;
  logic [W-1:0] src2  = '0;
  logic [3:0]   ctrl  = 4'b0000;
  logic [2:0]   bonus = 3'b000;
  logic         busy_o, done_o, zero_o, cout_o, overflow_o;
  logic [W-1:0] result_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .src1_i       (src1),
    .src2_i       (src2),
    .ALU_control_i(ctrl),
    .bonus_i      (bonus),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .zero_o       (zero_o),
    .cout_o       (cout_o),
    .overflow_o   (overflow_o)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        cout;
    logic        ovf;
    logic        chk_cout;
    logic [7:0]  n;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model_op(input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] c, input logic [2:0] bn);
    exp_t e;
    logic [32:0] s;
    logic lt, eq, pick;
    logic [2:0] sel;
    e = '0;
    e.n = 8'd32;
    s = 33'd0;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1100: e.res = ~(a | b);
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[31:0]; e.cout = s[32]; e.chk_cout = 1'b1;
        e.ovf = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'b0110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.res = s[31:0]; e.cout = s[32]; e.chk_cout = 1'b1;
        e.ovf = (a[31] != b[31]) && (s[31] != a[31]);
      end
      4'b0111: begin
        lt  = ($signed(a) < $signed(b));
        eq  = (a == b);
        sel = BONUS_ON ? bn : 3'b000;
        case (sel)
          3'b000:  pick = lt;
          3'b001:  pick = !lt && !eq;
          3'b010:  pick = lt || eq;
          3'b011:  pick = !lt;
          3'b110:  pick = eq;
          3'b100:  pick = !eq;
          default: pick = 1'b0;
        endcase
        e.res = {31'd0, pick};
        e.n = 8'd33;
      end
      default: e.res = 32'd0;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Reference model: tracks the operation in flight and the values currently held.
  int   cyc = 0;
  logic m_active = 1'b0;
  int   m_e0 = 0;
  exp_t m_exp = '0;
  exp_t m_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_exp    <= '0;
      m_prev   <= '0;
    end else if (start && !(m_active && cyc < m_e0 + int'(m_exp.n))) begin
      if (m_active) m_prev <= m_exp;
      m_exp    <= model_op(src1, src2, ctrl, bonus);
      m_e0     <= cyc + 1;
      m_active <= 1'b1;
    end else if (m_active && cyc >= m_e0 + int'(m_exp.n)) begin
      m_active <= 1'b0;
      m_prev   <= m_exp;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    exp_t cur;
    logic eb, ed;
    if (chk_en && !rst) begin
      ed  = m_active && (cyc == m_e0 + int'(m_exp.n));
      eb  = m_active && (cyc >= m_e0) && (cyc < m_e0 + int'(m_exp.n));
      cur = ed ? m_exp : m_prev;
      check("busy_o", busy_o, eb);
      check("done_o", done_o, ed);
      check("result_o", result_o, cur.res);
      check("zero_o", zero_o, cur.zero);
      check("overflow_o", overflow_o, cur.ovf);
      if (cur.chk_cout) check("cout_o", cout_o, cur.cout);
    end
  end

  task automatic wait_done(output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_o) begin
        lat = i + 1;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_op(input string name, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bit ok;
    wait_done(lat, ok);
    check({name, "_done_seen"}, 64'(ok), 64'd1);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_result"}, result_o, exp_res);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [2:0] bn,
                        input logic [31:0] exp_res, input int exp_lat);
    @(posedge clk); #1;
    src1 = a; src2 = b; ctrl = c; bonus = bn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op(name, exp_res, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_result", result_o, 32'd0);
    check("rst_zero", zero_o, 1'b0);
    check("rst_cout", cout_o, 1'b0);
    check("rst_ovf", overflow_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    run_op("add_5_7", 32'd5, 32'd7, 4'b0010, 3'b000, 32'd12, 33);
    check("add_zero", zero_o, 1'b0);
    check("add_cout", cout_o, 1'b0);
    check("add_ovf", overflow_o, 1'b0);

    run_op("sub_ovf", 32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0110, 3'b000, 32'h80000000, 33);
    check("sub_ovf_flag", overflow_o, 1'b1);

    run_op("sub_9_9", 32'd9, 32'd9, 4'b0110, 3'b000, 32'd0, 33);
    check("sub_9_9_zero", zero_o, 1'b1);
    check("sub_9_9_cout", cout_o, 1'b1);

    run_op("lt_m3_2", 32'hFFFFFFFD, 32'd2, 4'b0111, 3'b000, 32'd1, 34);
    run_op("gt_m3_2", 32'hFFFFFFFD, 32'd2, 4'b0111, 3'b001, BONUS_ON ? 32'd0 : 32'd1, 34);
    run_op("le_m3_2", 32'hFFFFFFFD, 32'd2, 4'b0111, 3'b010, 32'd1, 34);
    run_op("eq_5_5", 32'd5, 32'd5, 4'b0111, 3'b110, BONUS_ON ? 32'd1 : 32'd0, 34);
    run_op("ne_5_5", 32'd5, 32'd5, 4'b0111, 3'b100, 32'd0, 34);
    run_op("ge_5_5", 32'd5, 32'd5, 4'b0111, 3'b011, BONUS_ON ? 32'd1 : 32'd0, 34);
    run_op("lt_2_m3", 32'd2, 32'hFFFFFFFD, 4'b0111, 3'b000, 32'd0, 34);

    run_op("and", 32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 3'b000, 32'hF000F000, 33);
    run_op("or", 32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 3'b000, 32'hFFF0FFF0, 33);
    run_op("nor", 32'hF0F0F0F0, 32'hFF00FF00, 4'b1100, 3'b000, 32'h000F000F, 33);
    check("nor_ovf", overflow_o, 1'b0);

    // Reset while the bit counter is at 10.
    @(posedge clk); #1;
    src1 = 32'h00001234; src2 = 32'd1; ctrl = 4'b0010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_done", done_o, 1'b0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_zero", zero_o, 1'b0);
    check("midrst_ovf", overflow_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    run_op("add_1_1", 32'd1, 32'd1, 4'b0010, 3'b000, 32'd2, 33);

    // start held high through the run with new operands: back-to-back ops.
    @(posedge clk); #1;
    src1 = 32'd5; src2 = 32'd7; ctrl = 4'b0010; start = 1'b1;
    @(posedge clk); #1;
    src1 = 32'd9; src2 = 32'd9; ctrl = 4'b0110;
    finish_op("b2b_first", 32'd12, 33);
    @(posedge clk); #1;
    start = 1'b0;
    finish_op("b2b_second", 32'd0, 33);
    check("b2b_second_zero", zero_o, 1'b1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial sequencer that wraps the team's 1-bit ALU slice and turns it into a WIDTH-bit multi-cycle ALU. It processes one bit per clock, LSB first, and holds the ripple carry in a flop between cycles. For compare operations it runs a subtract pass first, then does one extra evaluation cycle that feeds the resulting `less` and `equal` flags back into the slice. It sits between the decode/control stage, which supplies operands and a start pulse, and the writeback path, which consumes `result_o` on `done_o`.

## Interface
- `WIDTH`, 32, operand/result width; legal range 2..64.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: start request; sampled only in IDLE or DONE.
- `src1_i` in WIDTH: operand A; captured on the accepted start.
- `src2_i` in WIDTH: operand B; captured on the accepted start.
- `ALU_control_i` in 4: `{A_invert, B_invert, op[1:0]}`; captured on start. Encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, SLT 0111.
- `bonus_i` in 3: compare select; captured on start. 000 lt, 001 gt, 010 le, 011 ge, 110 eq, 100 ne; any other code gives 0.
- `busy_o` out 1: high in RUN and CMP.
- `done_o` out 1: one-cycle pulse; `result_o` and the flags are valid in this cycle.
- `result_o` out WIDTH: result; held until the next accepted start.
- `zero_o` out 1: high when `result_o` == 0.
- `cout_o` out 1: carry out of the MSB; meaningful for ADD/SUB.
- `overflow_o` out 1: signed overflow, equal to carry-into-MSB XOR carry-out; forced to 0 for AND/OR/NOR/compare.

## Operation
- **States:** IDLE, RUN, CMP, DONE.
- **Reset:** state IDLE; all outputs 0; operand, result, carry and counter registers all 0.
- **IDLE/DONE with `start_i`=1:**
  - latch operands and control;
  - carry flop ← `B_invert`;
  - bit counter ← 0;
  - equal-accumulator ← 1;
  - go to RUN.
- **IDLE/DONE with `start_i`=0:** DONE returns to IDLE; IDLE stays in IDLE.
- **RUN, per cycle:**
  - slice inputs are `src1[cnt]`, `src2[cnt]`, the carry flop, `A_invert`/`B_invert`;
  - slice operation is op, except that op 11 is forced to ADD (10) so it produces the subtract sum;
  - the sum/logic bit is shifted into `result[WIDTH-1]` and the result register shifts right;
  - carry flop ← `cout`;
  - equal-accumulator is cleared if the sum bit is 1;
  - at `cnt`=WIDTH-1, record carry-in/out for overflow and `set` = MSB sum bit.
- **RUN exit at `cnt`=WIDTH-1:** op 11 goes to CMP; all other ops go to DONE.
- **CMP (one cycle):**
  - less = `set` XOR overflow;
  - equal = equal-accumulator;
  - slice evaluated with op 11, `comp`=1, `bonus` as latched;
  - `result_o` ← {WIDTH-1 zeros, compare bit};
  - go to DONE.
- **DONE:** `done_o`=1 and `busy_o`=0. A start in DONE is accepted, so back-to-back operations are allowed.
- **`start_i` in RUN/CMP:** ignored; no queuing.
- **Asynchronous reset mid-operation:** immediate return to IDLE with all outputs 0; no `done_o` is issued for the aborted operation.

## Timing
- Start accepted at edge E0. Bit k is processed at edge E(k+1).
- ADD/SUB/logic: the DONE cycle follows edge E(WIDTH), so `done_o` is high WIDTH+1 cycles after the start cycle.
- Compare: one cycle later than ADD/SUB/logic (WIDTH+2).
- `busy_o` rises in the cycle after E0.
- `result_o`, `zero_o`, `cout_o` and `overflow_o` update only at the edge that enters DONE. They are stable between operations.

## Configuration
- **`SERIAL_ALU_BONUS_EN` defined:**
  - full `bonus_i` decoding in CMP, as listed under Interface.
- **`SERIAL_ALU_BONUS_EN` undefined:**
  - `bonus_i` is ignored and the latched bonus is forced to 000, so op 11 is plain signed SLT;
  - CMP latency is unchanged.

## Structure
- Package `serial_alu_pkg` holds:
  - the state encoding (IDLE=0, RUN=1, CMP=2, DONE=3);
  - `ALU_control` constants (AND, OR, ADD, SUB, NOR, SLT);
  - bonus codes.
- Exactly one sub-module: a single instance of the team's 1-bit slice `alu_top`, reused in both RUN and CMP.
- The sequencer, counter (`$clog2(WIDTH)` bits), shift register and flag logic live in `serial_alu_seq`.

## Test plan
All scenarios use WIDTH=32.
- **ADD:** 5 + 7, ctrl 0010 → `result_o`=12, `cout_o`=0, `overflow_o`=0, `zero_o`=0; `done_o` exactly 33 cycles after the start cycle.
- **SUB with overflow:** 0x7FFFFFFF − 0xFFFFFFFF, ctrl 0110 → `result_o`=0x80000000, `overflow_o`=1. Also 9 − 9 → `result_o`=0, `zero_o`=1, `cout_o`=1.
- **Compares, ctrl 0111:**
  - −3 vs 2: bonus 000 → 1; bonus 001 → 0; bonus 010 → 1;
  - 5 vs 5: bonus 110 → 1; bonus 100 → 0; bonus 011 → 1;
  - `done_o` at 34 cycles.
- **Logic:** 0xF0F0F0F0 AND 0xFF00FF00 → 0xF000F000. OR → 0xFFF0FFF0. NOR (1100) → 0x000F000F.
- **Reset mid-RUN:** assert `rst_i` at bit 10 → immediately IDLE, outputs 0, no `done_o`. The next ADD 1 + 1 → 2.
- **Start handling:**
  - `start_i` held high for the whole run with new operands → the run in flight is unaffected;
  - the operation is re-accepted in DONE, giving back-to-back results with a single-cycle `done_o` each;
  - bench repeated with `SERIAL_ALU_BONUS_EN` undefined: bonus 110 on 5 vs 5 → 0.
